hex_display_ctrl: RTL and testbench

- Memory-mapped peripheral between the RISC-V core's IO bus and the hex-digit-to-7-segment decoder.
- Holds a 32-bit display value plus control and mask registers.
- Time-multiplexes one nibble at a time onto a shared decoder input and drives active-low digit-select lines.
- Supports enable, per-digit masking and blinking.

---
 rtl/hex_display_pkg.sv | 28 ++
 rtl/hex_scan_timer.sv | 49 ++++
 rtl/hex_display_ctrl.sv | 121 ++++++++++++
 tb/tb_hex_display_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display peripheral: register map,
// CTRL bit positions and the byte-lane merge helper.
package hex_display_pkg;

    localparam logic [3:0] VALUE_OFS = 4'h0;
    localparam logic [3:0] CTRL_OFS  = 4'h4;
    localparam logic [3:0] MASK_OFS  = 4'h8;

    localparam int EN_BIT    = 0;
    localparam int BLINK_BIT = 1;
    localparam int LZB_BIT   = 2;

    localparam logic [7:0] MASK_RST = 8'hFF;

    function automatic logic [31:0] be_merge(
        input logic [31:0] cur,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Digit scan timing: prescaler, digit index, rotation counter and
// blink phase. Runs continuously, independent of the display enable.
module hex_scan_timer #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] index,
    output logic          blink_phase
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [BW-1:0] rot_cnt;
    logic          slot_tc;
    logic          rot_tc;

    assign slot_tc = (presc == PW'(SCAN_DIV - 1));
    assign rot_tc  = slot_tc && (index == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            index       <= '0;
            rot_cnt     <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc <= slot_tc ? '0 : presc + 1'b1;
            if (slot_tc) begin
                index <= rot_tc ? '0 : index + 1'b1;
            end
            // phase flips on the same edge the index wraps to digit 0
            if (rot_tc) begin
                if (rot_cnt == BW'(BLINK_DIV - 1)) begin
                    rot_cnt     <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    rot_cnt <= rot_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Memory-mapped hex display controller with scan, mask and blink.
// Optional leading-zero blanking: HEX_DISPLAY_LEADING_ZERO_BLANK_EN.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [3:0]            addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wbe,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic [3:0]            nibble,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  blank
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    localparam int CTRL_W = 3;
`else
    localparam int CTRL_W = 2;
`endif

    logic [31:0]           value;
    logic [CTRL_W-1:0]     ctrl;
    logic [NUM_DIGITS-1:0] mask;
    logic [IW-1:0]         index;
    logic                  blink_phase;
    logic [31:0]           rd_mux;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  lz_blank;
    logic [NUM_DIGITS-1:0] cur_sel;

    hex_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_DIV  (BLINK_DIV)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .index       (index),
        .blink_phase (blink_phase)
    );

    always_comb begin
        rd_mux = '0;
        case (addr)
            VALUE_OFS: rd_mux = value;
            CTRL_OFS:  rd_mux = 32'(ctrl);
            MASK_OFS:  rd_mux = 32'(mask);
            default:   rd_mux = '0;
        endcase
    end

    // rdata is captured from the pre-write registers on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            ctrl  <= '0;
            mask  <= MASK_RST[NUM_DIGITS-1:0];
            rdata <= '0;
            ready <= 1'b0;
        end else begin
            ready <= wr_en | rd_en;
            rdata <= rd_en ? rd_mux : '0;
            if (wr_en) begin
                case (addr)
                    VALUE_OFS: value <= be_merge(value, wdata, wbe);
                    CTRL_OFS:  if (wbe[0]) ctrl <= wdata[CTRL_W-1:0];
                    MASK_OFS:  if (wbe[0]) mask <= wdata[NUM_DIGITS-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;

    // lz[i]: digit i and everything above it are zero; digit 0 exempt
    always_comb begin
        logic zacc;
        zacc = 1'b1;
        lz   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zacc  = zacc & (value[4*i +: 4] == 4'h0);
            lz[i] = zacc && (i != 0);
        end
    end

    assign lz_blank = ctrl[LZB_BIT] & lz[index];
`else
    assign lz_blank = 1'b0;
`endif

    assign cur_nib   = value[{index, 2'b00} +: 4];
    assign cur_blank = ~ctrl[EN_BIT] | ~mask[index]
                     | (ctrl[BLINK_BIT] & blink_phase) | lz_blank;
    assign cur_sel   = ~(NUM_DIGITS'(1) << index);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nibble    <= 4'h0;
            digit_sel <= '1;
            blank     <= 1'b1;
        end else begin
            nibble    <= cur_nib;
            blank     <= cur_blank;
            digit_sel <= cur_blank ? '1 : cur_sel;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl with a short scan period.
// Define HEX_DISPLAY_LEADING_ZERO_BLANK_EN to cover leading-zero blanking.
module tb_hex_display_ctrl;

    localparam int ND = 8;
    localparam int SD = 4;
    localparam int BD = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [3:0]    addr = 4'h0;
    logic [31:0]   wdata = 32'h0;
    logic [3:0]    wbe = 4'h0;
    logic [31:0]   rdata;
    logic          ready;
    logic [3:0]    nibble;
    logic [ND-1:0] digit_sel;
    logic          blank;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];
    logic [32:0] mon_e;
    string       mon_n;

    hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .wbe       (wbe),
        .rdata     (rdata),
        .ready     (ready),
        .nibble    (nibble),
        .digit_sel (digit_sel),
        .blank     (blank)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready rdata=%h", rdata);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (mon_e[32]) begin
                    checks++;
                    if (rdata !== mon_e[31:0]) begin
                        errors++;
                        $display("FAIL %s got %h want %h", mon_n, rdata, mon_e[31:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic bus(input logic we, input logic re, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] exp, input string nm);
        @(negedge clk);
        wr_en = we;
        rd_en = re;
        addr  = a;
        wdata = d;
        wbe   = be;
        exp_q.push_back({re, exp});
        name_q.push_back(nm);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        bus(1'b1, 1'b0, a, d, be, 32'h0, "wr");
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
        bus(1'b0, 1'b1, a, 32'h0, 4'h0, exp, nm);
    endtask

    task automatic scan_check(input logic [7:0] prev_sel, input logic [7:0] start_sel,
                              input int start_digit, input int nslots,
                              input logic [31:0] val,
                              input logic [7:0] shown0, input logic [7:0] shown1,
                              input string nm);
        logic [7:0] prev;
        logic [7:0] sh;
        logic [7:0] one;
        logic [7:0] exp_sel;
        logic       ok;
        int         d;
        int         r;
        one  = 8'h01;
        prev = 8'hxx;
        ok   = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (prev === prev_sel && digit_sel === start_sel) begin
                ok = 1'b1;
                break;
            end
            prev = digit_sel;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_align got %h want %h", nm, digit_sel, start_sel);
            return;
        end
        for (int k = 0; k < nslots * 4; k++) begin
            if (k > 0) @(negedge clk);
            d  = (start_digit + k / 4) % ND;
            r  = (start_digit + k / 4) / ND;
            sh = (r % 2 == 1) ? shown1 : shown0;
            exp_sel = sh[d] ? ~(one << d) : 8'hFF;
            chk(nm, {19'h0, nibble, digit_sel, blank},
                {19'h0, val[4*d +: 4], exp_sel, ~sh[d]});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] prev;
        logic       ok;
        logic [31:0] ctrl_rb;
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
        ctrl_rb = 32'h7;
`else
        ctrl_rb = 32'h3;
`endif
        #1 rst = 1'b1;
        #7;
        chk("rst_sel", 32'(digit_sel), 32'hFF);
        chk("rst_blank", 32'(blank), 32'h1);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_nibble", 32'(nibble), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        rd(4'h8, 32'h000000FF, "mask_rst");
        rd(4'h0, 32'h0, "value_rst");
        rd(4'h4, 32'h0, "ctrl_rst");

        wr(4'h0, 32'h1234ABCD, 4'hF);
        wr(4'h4, 32'h1, 4'hF);
        rd(4'h0, 32'h1234ABCD, "value_rb");
        scan_check(8'h7F, 8'hFE, 0, 9, 32'h1234ABCD, 8'hFF, 8'hFF, "scan_main");

        @(negedge clk);
        rd_en = 1'b1;
        addr  = 4'h4;
        exp_q.push_back({1'b1, 32'h1});
        name_q.push_back("rd_timing");
        @(negedge clk);
        rd_en = 1'b0;
        chk("ready_n1", 32'(ready), 32'h1);
        @(negedge clk);
        chk("rdata_n2", rdata, 32'h0);
        chk("ready_n2", 32'(ready), 32'h0);

        rd(4'hC, 32'h0, "unmapped_rd");
        wr(4'hC, 32'hFFFFFFFF, 4'hF);
        rd(4'h0, 32'h1234ABCD, "unmapped_wr");

        bus(1'b1, 1'b1, 4'h0, 32'hFFFFFFFF, 4'hF, 32'h1234ABCD, "rw_same");
        rd(4'h0, 32'hFFFFFFFF, "rw_after");
        wr(4'h0, 32'h0, 4'b0010);
        rd(4'h0, 32'hFFFF00FF, "byte_en");

        wr(4'h4, 32'hFFFFFFFF, 4'hF);
        rd(4'h4, ctrl_rb, "ctrl_bits");
        wr(4'h8, 32'hFFFFFFFF, 4'hF);
        rd(4'h8, 32'h000000FF, "mask_bits");

        wr(4'h4, 32'h1, 4'hF);
        wr(4'h0, 32'h89ABCDEF, 4'hF);
        prev = 8'hxx;
        ok   = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (prev === 8'h7F && digit_sel === 8'hFE) begin
                ok = 1'b1;
                break;
            end
            prev = digit_sel;
        end
        chk("latency_align", 32'(ok), 32'h1);
        wr_en = 1'b1;
        addr  = 4'h0;
        wdata = 32'h89ABCDE5;
        wbe   = 4'hF;
        exp_q.push_back({1'b0, 32'h0});
        name_q.push_back("wr");
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        chk("value_latency", {20'h0, nibble, digit_sel}, {20'h0, 4'h5, 8'hFE});

        wr(4'h8, 32'h0000000F, 4'hF);
        wr(4'h4, 32'h3, 4'hF);
        repeat (40) @(negedge clk);
        scan_check(8'hFE, 8'hFD, 1, 17, 32'h89ABCDE5, 8'h0F, 8'h00, "blink");

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
        wr(4'h8, 32'hFF, 4'hF);
        wr(4'h0, 32'h000000A0, 4'hF);
        wr(4'h4, 32'h5, 4'hF);
        repeat (40) @(negedge clk);
        scan_check(8'hFF, 8'hFE, 0, 8, 32'h000000A0, 8'h03, 8'h03, "lzb_a0");
        wr(4'h0, 32'h0, 4'hF);
        repeat (40) @(negedge clk);
        scan_check(8'hFF, 8'hFE, 0, 8, 32'h0, 8'h01, 8'h01, "lzb_zero");
`endif

        wr(4'h8, 32'hFF, 4'hF);
        wr(4'h4, 32'h1, 4'hF);
        repeat (10) @(negedge clk);
        wr_en = 1'b1;
        addr  = 4'h0;
        wdata = 32'h0;
        wbe   = 4'hF;
        @(posedge clk);
        #2;
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'h0);
        chk("midrst_sel", 32'(digit_sel), 32'hFF);
        chk("midrst_blank", 32'(blank), 32'h1);
        chk("midrst_nibble", 32'(nibble), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(4'h8, 32'h000000FF, "mask_after_rst");
        rd(4'h0, 32'h0, "value_after_rst");
        rd(4'h4, 32'h0, "ctrl_after_rst");

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
